// File: rtl/pixel_fifo_param_if.sv
// Handshake/data bundle for pixel_fifo_param.
// The master side is the producer/consumer environment and the slave side is the FIFO.
interface pixel_fifo_param_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned USEDW_W = 12
) ();
    logic [DATA_W-1:0]  datain;
    logic               wrreq;
    logic               rdreq;
    logic [USEDW_W-1:0] af_th;
    logic [USEDW_W-1:0] ae_th;
    logic               clr_err;
    logic [DATA_W-1:0]  dataout;
    logic [USEDW_W-1:0] usedw;
    logic               full;
    logic               empty;
    logic               almost_full;
    logic               almost_empty;
    logic               overflow;
    logic               underflow;

    modport master (
        output datain, wrreq, rdreq, af_th, ae_th, clr_err,
        input  dataout, usedw, full, empty, almost_full, almost_empty, overflow, underflow
    );

    modport slave (
        input  datain, wrreq, rdreq, af_th, ae_th, clr_err,
        output dataout, usedw, full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/pixel_fifo_param.sv
// Parametrised single-clock pixel FIFO with optional show-ahead output, run-time
// almost-full/almost-empty thresholds, a full-range usedw count and sticky error flags.
module pixel_fifo_param #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned USEDW_W    = 12,
    parameter int unsigned SHOW_AHEAD = 0
) (
    input logic               clk,
    input logic               sclr,
    pixel_fifo_param_if.slave bus
);
    localparam int unsigned        PTR_W   = $clog2(DEPTH);
    localparam logic [USEDW_W-1:0] DEPTH_U = USEDW_W'(DEPTH);

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [USEDW_W-1:0] usedw_q, usedw_d;
    logic               full_q, empty_q, af_q, ae_q;
    logic               ovf_q, ovf_d, unf_q, unf_d;
    logic               wr_acc, rd_acc;

    always_comb begin
        wr_acc  = bus.wrreq && !full_q;
        rd_acc  = bus.rdreq && !empty_q;
        usedw_d = usedw_q;
        if (wr_acc && !rd_acc) begin
            usedw_d = usedw_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            usedw_d = usedw_q - 1'b1;
        end
        // A new error in the same cycle as clr_err keeps the flag set.
        ovf_d = ovf_q;
        if (bus.wrreq && full_q) begin
            ovf_d = 1'b1;
        end else if (bus.clr_err) begin
            ovf_d = 1'b0;
        end
        unf_d = unf_q;
        if (bus.rdreq && empty_q) begin
            unf_d = 1'b1;
        end else if (bus.clr_err) begin
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
            usedw_q <= usedw_d;
            // Flags come from the next count so they always agree with usedw.
            full_q  <= (usedw_d == DEPTH_U);
            empty_q <= (usedw_d == '0);
            af_q    <= (usedw_d >= bus.af_th);
            ae_q    <= (usedw_d < bus.ae_th);
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!sclr && wr_acc) begin
            mem[wr_ptr_q] <= bus.datain;
        end
    end

    if (SHOW_AHEAD != 0) begin : g_show_ahead
        logic [DATA_W-1:0] hold_q;

        // Tracks the head word so the last shown value persists once the FIFO drains.
        always_ff @(posedge clk) begin
            if (sclr) begin
                hold_q <= '0;
            end else if (!empty_q) begin
                hold_q <= mem[rd_ptr_q];
            end
        end

        assign bus.dataout = empty_q ? hold_q : mem[rd_ptr_q];
    end else begin : g_normal
        logic [DATA_W-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (sclr) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem[rd_ptr_q];
            end
        end

        assign bus.dataout = dout_q;
    end

    assign bus.usedw        = usedw_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_pixel_fifo_param.sv
// Directed bench for pixel_fifo_param: a queue scoreboard tracks contents, count and flags
// of a 16-deep normal-mode FIFO; a second show-ahead instance gets a short directed check.
module tb_pixel_fifo_param;
    logic clk = 1'b0;
    logic sclr;
    always #5 clk = ~clk;

    pixel_fifo_param_if #(.DATA_W(8), .USEDW_W(5)) f_if ();
    pixel_fifo_param_if #(.DATA_W(8), .USEDW_W(5)) sa_if ();

    pixel_fifo_param #(.DATA_W(8), .DEPTH(16), .USEDW_W(5), .SHOW_AHEAD(0)) dut (
        .clk  (clk),
        .sclr (sclr),
        .bus  (f_if.slave)
    );

    pixel_fifo_param #(.DATA_W(8), .DEPTH(16), .USEDW_W(5), .SHOW_AHEAD(1)) dut_sa (
        .clk  (clk),
        .sclr (sclr),
        .bus  (sa_if.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] m_dout;
    bit         m_ovf, m_unf, m_af, m_ae;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the normal FIFO, model update, then compare every output.
    task automatic step(input string name, input bit wr, input logic [7:0] din, input bit rd,
                        input bit clr = 1'b0, input bit rst = 1'b0);
        bit wa, ra;
        sclr         = rst;
        f_if.wrreq   = wr;
        f_if.datain  = din;
        f_if.rdreq   = rd;
        f_if.clr_err = clr;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_dout = 8'h00;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_af   = 1'b0;
            m_ae   = 1'b1;
        end else begin
            wa = wr && (q.size() < 16);
            ra = rd && (q.size() > 0);
            if (wr && !wa) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (rd && !ra) m_unf = 1'b1;
            else if (clr) m_unf = 1'b0;
            if (ra) m_dout = q.pop_front();
            if (wa) q.push_back(din);
            m_af = q.size() >= int'(f_if.af_th);
            m_ae = q.size() < int'(f_if.ae_th);
        end
        #1;
        sclr         = 1'b0;
        f_if.wrreq   = 1'b0;
        f_if.rdreq   = 1'b0;
        f_if.clr_err = 1'b0;
        chk({name, ".usedw"}, 32'(f_if.usedw), 32'(q.size()));
        chk({name, ".full"}, 32'(f_if.full), 32'(q.size() == 16));
        chk({name, ".empty"}, 32'(f_if.empty), 32'(q.size() == 0));
        chk({name, ".almost_full"}, 32'(f_if.almost_full), 32'(m_af));
        chk({name, ".almost_empty"}, 32'(f_if.almost_empty), 32'(m_ae));
        chk({name, ".overflow"}, 32'(f_if.overflow), 32'(m_ovf));
        chk({name, ".underflow"}, 32'(f_if.underflow), 32'(m_unf));
        chk({name, ".dataout"}, 32'(f_if.dataout), 32'(m_dout));
    endtask

    task automatic sa_step(input bit wr, input logic [7:0] din, input bit rd);
        sa_if.wrreq  = wr;
        sa_if.datain = din;
        sa_if.rdreq  = rd;
        @(posedge clk);
        #1;
        sa_if.wrreq = 1'b0;
        sa_if.rdreq = 1'b0;
    endtask

    initial begin
        sclr          = 1'b1;
        f_if.datain   = '0;
        f_if.wrreq    = 1'b0;
        f_if.rdreq    = 1'b0;
        f_if.clr_err  = 1'b0;
        f_if.af_th    = 5'd12;
        f_if.ae_th    = 5'd3;
        sa_if.datain  = '0;
        sa_if.wrreq   = 1'b0;
        sa_if.rdreq   = 1'b0;
        sa_if.clr_err = 1'b0;
        sa_if.af_th   = 5'd12;
        sa_if.ae_th   = 5'd3;

        step("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Fill and drain in normal mode.
        for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1);

        // Overflow, underflow, clear, and set winning over clear.
        for (int i = 0; i < 16; i++) step("fill2", 1'b1, 8'(8'h30 + i), 1'b0);
        step("ovf_wr", 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 16; i++) step("drain2", 1'b0, 8'h00, 1'b1);
        step("unf_rd", 1'b0, 8'h00, 1'b1);
        step("clr_err", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step("fill3", 1'b1, 8'(8'h50 + i), 1'b0);
        step("ovf_and_clr", 1'b1, 8'hAB, 1'b0, 1'b1);
        step("ovf_clr_only", 1'b0, 8'h00, 1'b0, 1'b1);

        // Simultaneous requests across the pointer wrap.
        step("rst_sim", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("pre5", 1'b1, 8'(i), 1'b0);
        for (int i = 5; i < 25; i++) step("wr_rd", 1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 5; i++) step("post5", 1'b0, 8'h00, 1'b1);
        step("wr_rd_empty", 1'b1, 8'hC3, 1'b1);
        step("rd_c3", 1'b0, 8'h00, 1'b1);

        // Reset mid-operation overrides a concurrent write.
        step("rst_a", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step("fill9", 1'b1, 8'(8'h90 + i), 1'b0);
        step("rst_wr", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        step("wr_new", 1'b1, 8'h77, 1'b0);
        step("rd_new", 1'b0, 8'h00, 1'b1);

        // Run-time thresholds.
        step("rst_th", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step("fill8", 1'b1, 8'(i), 1'b0);
        f_if.af_th = 5'd8;
        step("af_8", 1'b0, 8'h00, 1'b0);
        f_if.ae_th = 5'd9;
        step("ae_9", 1'b0, 8'h00, 1'b0);
        f_if.af_th = 5'd0;
        f_if.ae_th = 5'd0;
        step("th_zero", 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step("drain_th0", 1'b0, 8'h00, 1'b1);
        f_if.af_th = 5'd12;
        f_if.ae_th = 5'd3;
        step("th_restore", 1'b0, 8'h00, 1'b0);

        // Show-ahead instance; its reset came from the shared sclr pulses above.
        chk("sa.reset_empty", 32'(sa_if.empty), 32'd1);
        chk("sa.reset_dataout", 32'(sa_if.dataout), 32'h00);
        sa_step(1'b1, 8'h5A, 1'b0);
        chk("sa.t1_empty", 32'(sa_if.empty), 32'd0);
        chk("sa.t1_dataout", 32'(sa_if.dataout), 32'h5A);
        sa_step(1'b1, 8'h5B, 1'b0);
        chk("sa.head_hold", 32'(sa_if.dataout), 32'h5A);
        chk("sa.usedw2", 32'(sa_if.usedw), 32'd2);
        sa_step(1'b0, 8'h00, 1'b1);
        chk("sa.after_rd", 32'(sa_if.dataout), 32'h5B);
        chk("sa.usedw1", 32'(sa_if.usedw), 32'd1);
        sa_step(1'b0, 8'h00, 1'b1);
        chk("sa.drained_empty", 32'(sa_if.empty), 32'd1);
        chk("sa.drained_hold", 32'(sa_if.dataout), 32'h5B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
